// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the prog_loader serial program driver.
// Optional PROG_LOADER_PARITY_EN adds an even-parity bit to each frame.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_INSTR = 2'b01,
        MODE_REGS  = 2'b10,
        MODE_RUN   = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_I,
        S_SHIFT_I,
        S_GAP_I,
        S_PRE_R,
        S_SHIFT_R,
        S_GAP_R,
        S_RUN,
        S_FIN
    } state_t;

    localparam int unsigned PRE_CYC = 2;

    // Serial frame length: addr + data (+ parity) + stop bit.
    function automatic int unsigned frame_w(input int unsigned dw, input int unsigned aw);
`ifdef PROG_LOADER_PARITY_EN
        return 2 + dw + aw;
`else
        return 1 + dw + aw;
`endif
    endfunction

    function automatic mode_t mode_of(input state_t s);
        case (s)
            S_PRE_I, S_SHIFT_I: return MODE_INSTR;
            S_PRE_R, S_SHIFT_R: return MODE_REGS;
            S_RUN:              return MODE_RUN;
            default:            return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/prog_loader_frame_shifter.sv
// Loads one {stop, [parity], word, addr} frame and shifts it out LSB first.
// PROG_LOADER_PARITY_EN inserts even parity over word and addr below the stop bit.
module prog_loader_frame_shifter
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    localparam int unsigned FRAME_W = frame_w(DATA_W, ADDR_W),
    localparam int unsigned BC_W    = $clog2(FRAME_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic [ADDR_W-1:0] addr,
    output logic              mosi,
    output logic [BC_W-1:0]   bit_cnt,
    output logic              last_bit
);

    logic [FRAME_W-1:0] sreg;
    logic [FRAME_W-1:0] frame_c;
    logic               active;

    always_comb begin
`ifdef PROG_LOADER_PARITY_EN
        frame_c = {1'b0, ^{word, addr}, word, addr};
`else
        frame_c = {1'b0, word, addr};
`endif
    end

    assign last_bit = active && (bit_cnt == BC_W'(FRAME_W - 1));
    // Zero fill leaves the line low once the stop bit has gone out.
    assign mosi     = sreg[0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg    <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
        end else if (load) begin
            sreg    <= frame_c;
            bit_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            sreg    <= sreg >> 1;
            bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
            active  <= !last_bit;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams host-written instruction/register images bank by bank to the tiny processor.
// Build option PROG_LOADER_PARITY_EN: parity bit in every frame (see frame shifter).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned N_INSTR = 16,
    parameter int unsigned N_REGS  = 16,
    parameter int unsigned GAP_CYC = 1,
    localparam int unsigned MAXD   = (N_INSTR > N_REGS) ? N_INSTR : N_REGS,
    localparam int unsigned AW     = (MAXD > 1) ? $clog2(MAXD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              done_in,
    output logic              mosi_out,
    output logic [1:0]        mode_out,
    output logic              busy,
    output logic              done_out
);

    localparam int unsigned BANK    = 1 << ADDR_W;
    localparam int unsigned MEM_D   = 1 << AW;
    localparam int unsigned IDX_W   = $clog2(MAXD + BANK + 1);
    localparam int unsigned CYC_MAX = (PRE_CYC > GAP_CYC) ? PRE_CYC : GAP_CYC;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned BC_W    = $clog2(frame_w(DATA_W, ADDR_W));

    state_t             state, state_nx;
    mode_t              mode_r;
    logic [CYC_W-1:0]   cyc, cyc_nx;
    logic [ADDR_W-1:0]  word, word_nx;
    logic [IDX_W-1:0]   base, base_nx;
    logic               load_c, clr_c;
    logic               sh_last;
    logic [BC_W-1:0]    sh_bit_cnt_unused;

    logic [DATA_W-1:0]  imem [MEM_D];
    logic [DATA_W-1:0]  dmem [MEM_D];
    logic [DATA_W-1:0]  ld_word;
    logic               wr_ok;

    logic [IDX_W-1:0]   gidx;
    logic               has_r, nb_i, nb_r, last_i, last_r;

    // Bank bookkeeping: base is bank*BANK, word the in-bank index.
    assign gidx   = base + IDX_W'(word);
    assign has_r  = base < IDX_W'(N_REGS);
    assign nb_i   = (base + IDX_W'(BANK)) < IDX_W'(N_INSTR);
    assign nb_r   = (base + IDX_W'(BANK)) < IDX_W'(N_REGS);
    assign last_i = (word == ADDR_W'(BANK - 1)) || ((gidx + IDX_W'(1)) >= IDX_W'(N_INSTR));
    assign last_r = (word == ADDR_W'(BANK - 1)) || ((gidx + IDX_W'(1)) >= IDX_W'(N_REGS));

    assign wr_ok = wr_en && (state == S_IDLE || state == S_FIN) &&
                   (wr_sel ? (32'(wr_addr) < N_REGS) : (32'(wr_addr) < N_INSTR));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel) dmem[wr_addr] <= wr_data;
            else        imem[wr_addr] <= wr_data;
        end
    end

    assign ld_word = (state == S_PRE_R) ? dmem[AW'(gidx)] : imem[AW'(gidx)];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cyc      <= '0;
            word     <= '0;
            base     <= '0;
            mode_r   <= MODE_IDLE;
            busy     <= 1'b0;
            done_out <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state    <= state_nx;
            cyc      <= cyc_nx;
            word     <= word_nx;
            base     <= base_nx;
            mode_r   <= mode_of(state_nx);
            busy     <= (state_nx != S_IDLE);
            done_out <= (state_nx == S_FIN);
            wr_err   <= wr_en && !wr_ok;
        end
    end

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        word_nx  = word;
        base_nx  = base;
        load_c   = 1'b0;
        clr_c    = 1'b0;
        case (state)
            S_IDLE: begin
                cyc_nx  = '0;
                word_nx = '0;
                base_nx = '0;
                if (start) state_nx = S_PRE_I;
            end
            S_PRE_I, S_PRE_R: begin
                if (cyc == CYC_W'(PRE_CYC - 1)) begin
                    cyc_nx   = '0;
                    load_c   = 1'b1;
                    state_nx = (state == S_PRE_I) ? S_SHIFT_I : S_SHIFT_R;
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            S_SHIFT_I: if (sh_last) state_nx = S_GAP_I;
            S_SHIFT_R: if (sh_last) state_nx = S_GAP_R;
            S_GAP_I, S_GAP_R: begin
                if (cyc == CYC_W'(GAP_CYC - 1)) begin
                    cyc_nx = '0;
                    if (state == S_GAP_I && !last_i) begin
                        word_nx  = word + ADDR_W'(1);
                        state_nx = S_PRE_I;
                    end else if (state == S_GAP_R && !last_r) begin
                        word_nx  = word + ADDR_W'(1);
                        state_nx = S_PRE_R;
                    end else begin
                        word_nx  = '0;
                        state_nx = (state == S_GAP_I && has_r) ? S_PRE_R : S_RUN;
                    end
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            S_RUN: begin
                if (done_in) begin
                    base_nx  = base + IDX_W'(BANK);
                    word_nx  = '0;
                    state_nx = nb_i ? S_PRE_I : (nb_r ? S_PRE_R : S_FIN);
                end
            end
            S_FIN: begin
                if (!start) begin
                    state_nx = S_IDLE;
                    base_nx  = '0;
                    word_nx  = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            cyc_nx   = '0;
            word_nx  = '0;
            base_nx  = '0;
            load_c   = 1'b0;
            clr_c    = 1'b1;
        end
    end

    // Processor sees the run phase end in the same cycle it signals done.
    assign mode_out = (state == S_RUN && done_in) ? MODE_IDLE : mode_r;

    prog_loader_frame_shifter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_c),
        .load     (load_c),
        .word     (ld_word),
        .addr     (word),
        .mosi     (mosi_out),
        .bit_cnt  (sh_bit_cnt_unused),
        .last_bit (sh_last)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random images and run delays against a frame-stream model.
module tb_prog_loader;

    localparam int unsigned DW   = 8;
    localparam int unsigned ADW  = 4;
    localparam int unsigned NI   = 20;
    localparam int unsigned NR   = 16;
    localparam int unsigned GAP  = 1;
    localparam int unsigned BANK = 16;
    localparam int unsigned WA   = 5;
`ifdef PROG_LOADER_PARITY_EN
    localparam int unsigned FW = 2 + DW + ADW;
`else
    localparam int unsigned FW = 1 + DW + ADW;
`endif
    localparam int unsigned PERIOD = 2 + FW + GAP;

    logic          clk, rst, start, abort, wr_en, wr_sel, done_in;
    logic [WA-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err, mosi_out, busy, done_out;
    logic [1:0]    mode_out;

    prog_loader #(
        .DATA_W (DW), .ADDR_W (ADW), .N_INSTR (NI), .N_REGS (NR), .GAP_CYC (GAP)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort),
        .wr_en (wr_en), .wr_sel (wr_sel), .wr_addr (wr_addr), .wr_data (wr_data),
        .wr_err (wr_err), .done_in (done_in), .mosi_out (mosi_out),
        .mode_out (mode_out), .busy (busy), .done_out (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] im [NI];
    logic [DW-1:0] dm [NR];

    typedef struct packed {
        logic [1:0] m;
        logic       b;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned sec_cnt(input int unsigned depth, input int unsigned bank);
        if (depth <= bank * BANK) return 0;
        return (depth - bank * BANK > BANK) ? BANK : depth - bank * BANK;
    endfunction

    function automatic logic frame_bit(input logic [DW-1:0] w, input int unsigned a, input int unsigned b);
        logic [31:0] f;
        f = (32'(w) << ADW) | (a & (BANK - 1));
`ifdef PROG_LOADER_PARITY_EN
        f = f | (32'(^f) << (DW + ADW));
`endif
        return f[b];
    endfunction

    // Expected (mode, mosi) per cycle for one bank, straight from the frame rules.
    task automatic build_bank(input int unsigned bank);
        q.delete();
        for (int sec = 0; sec < 2; sec++) begin
            int unsigned n;
            logic [1:0]  m;
            n = sec_cnt(sec ? NR : NI, bank);
            m = sec ? 2'b10 : 2'b01;
            for (int unsigned k = 0; k < n; k++) begin
                logic [DW-1:0] w;
                w = sec ? dm[bank * BANK + k] : im[bank * BANK + k];
                repeat (2) q.push_back('{m: m, b: 1'b0});
                for (int unsigned b = 0; b < FW; b++) q.push_back('{m: m, b: frame_bit(w, k, b)});
                repeat (GAP) q.push_back('{m: 2'b00, b: 1'b0});
            end
        end
    endtask

    task automatic stream(input int abort_at, input int wr_at, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < int'(q.size()); i++) begin
            done_in = (i == int'(q.size()) - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (i == wr_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = WA'(3); wr_data = 8'hFF;
            end else begin
                wr_en = 1'b0;
            end
            if (wr_at >= 0 && i == wr_at + 1) chk("wr_err_busy", 32'(wr_err), 1);
            chk($sformatf("mode[%0d]", i), 32'(mode_out), 32'(q[i].m));
            chk($sformatf("mosi[%0d]", i), 32'(mosi_out), 32'(q[i].b));
            chk($sformatf("busy[%0d]", i), 32'(busy), 1);
            if (i == abort_at) begin
                abort = 1'b1; start = 1'b0;
                tick;
                abort = 1'b0; wr_en = 1'b0; done_in = 1'b0;
                chk("abort_mode", 32'(mode_out), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_mosi", 32'(mosi_out), 0);
                aborted = 1'b1;
                return;
            end
            tick;
        end
        wr_en = 1'b0;
        done_in = 1'b0;
    endtask

    task automatic run_phase(input int unsigned bank);
        int unsigned d;
        d = $urandom_range(1, 5);
        for (int unsigned k = 0; k < d; k++) begin
            done_in = 1'b0;
            #1;
            chk($sformatf("run_mode b%0d", bank), 32'(mode_out), 3);
            tick;
        end
        done_in = 1'b1;
        #1;
        chk($sformatf("run_done_mode b%0d", bank), 32'(mode_out), 0);
        tick;
        done_in = 1'b0;
    endtask

    task automatic full_load(input int abort_at, input int wr_at, output bit aborted);
        int ab_at, w_at;
        ab_at = abort_at;
        w_at  = wr_at;
        aborted = 1'b0;
        start = 1'b1;
        tick;
        for (int unsigned bank = 0; bank < 8; bank++) begin
            if (sec_cnt(NI, bank) == 0 && sec_cnt(NR, bank) == 0) break;
            build_bank(bank);
            stream(ab_at, w_at, aborted);
            if (aborted) return;
            ab_at = -1;
            w_at  = -1;
            run_phase(bank);
        end
        chk("fin_done", 32'(done_out), 1);
        chk("fin_mode", 32'(mode_out), 0);
        chk("fin_busy", 32'(busy), 1);
    endtask

    task automatic host_write(input logic sel, input int unsigned addr, input logic [DW-1:0] data,
                              input logic exp_err);
        wr_en = 1'b1; wr_sel = sel; wr_addr = WA'(addr); wr_data = data;
        tick;
        wr_en = 1'b0;
        chk($sformatf("wr_err s%0d a%0d", sel, addr), 32'(wr_err), 32'(exp_err));
    endtask

    task automatic leave_fin;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("fin_hold_done", 32'(done_out), 1);
            chk("fin_hold_mode", 32'(mode_out), 0);
        end
        start = 1'b0;
        tick;
        chk("idle_done", 32'(done_out), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
        wr_addr = '0; wr_data = '0; done_in = 1'b0;
        repeat (3) tick;
        chk("rst_mosi", 32'(mosi_out), 0);
        chk("rst_mode", 32'(mode_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        rst = 1'b0;
        tick;

        for (int unsigned i = 0; i < NI; i++) begin
            im[i] = DW'(32'hA0 + i);
            host_write(1'b0, i, im[i], 1'b0);
        end
        for (int unsigned i = 0; i < NR; i++) begin
            dm[i] = DW'(32'h50 + i);
            host_write(1'b1, i, dm[i], 1'b0);
        end
        host_write(1'b0, NI, 8'h11, 1'b1);
        host_write(1'b1, $urandom_range(NR, 31), 8'h22, 1'b1);

        // Load with a rejected write during the first frame, then hold start in FIN.
        full_load(-1, 5, ab);
        leave_fin;

        // Abort mid-frame of word 3; the images must still hold the original data.
        full_load(int'(3 * PERIOD + 2 + 6), -1, ab);
        chk("aborted_idle_done", 32'(done_out), 0);

        for (int unsigned i = 0; i < NI; i++) begin
            im[i] = (i == 1) ? 8'h03 : DW'($urandom);
            host_write(1'b0, i, im[i], 1'b0);
        end
        for (int unsigned i = 0; i < NR; i++) begin
            dm[i] = DW'($urandom);
            host_write(1'b1, i, dm[i], 1'b0);
        end
        full_load(-1, -1, ab);
        leave_fin;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
